// File: rtl/aurora_tx_arbiter.sv
// rtl/aurora_tx_arbiter.sv - packet-level round-robin arbiter onto one Aurora TX AXI-Stream port
//
// Shares a single Aurora 64B/66B framing TX stream between NUM_SRC packet
// sources. A grant is held from the first beat to tlast, so packets never
// interleave. New grants need channel_up; a packet caught in flight when the
// channel drops is drained from its source and discarded whole.
//
// Ports:
//   user_clk, user_rst_n   Aurora user clock, asynchronous active-low reset
//   channel_up             Aurora channel status (user_clk domain)
//   s_tdata/tkeep/tlast/tvalid/tready
//                          NUM_SRC packed source streams, source i at slice i
//   m_tdata/tkeep/tlast/tvalid/tready
//                          stream to Aurora s_axi_tx_*
//   grant_id               current or most recently granted source
//   busy                   high while sending or flushing
//   pkt_cnt, drop_cnt      saturating forwarded / flushed packet counters

module aurora_tx_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int CNT_W   = 16
) (
  input  logic                   user_clk,
  input  logic                   user_rst_n,
  input  logic                   channel_up,
  input  logic [NUM_SRC*64-1:0]  s_tdata,
  input  logic [NUM_SRC*8-1:0]   s_tkeep,
  input  logic [NUM_SRC-1:0]     s_tlast,
  input  logic [NUM_SRC-1:0]     s_tvalid,
  output logic [NUM_SRC-1:0]     s_tready,
  output logic [63:0]            m_tdata,
  output logic [7:0]             m_tkeep,
  output logic                   m_tlast,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic [2:0]             grant_id,
  output logic                   busy,
  output logic [CNT_W-1:0]       pkt_cnt,
  output logic [CNT_W-1:0]       drop_cnt
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SEND  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  localparam logic [2:0]       LAST_IDX = 3'(NUM_SRC - 1);
  localparam logic [3:0]       SRC_CNT  = 4'(NUM_SRC);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [1:0]         state;
  logic [2:0]         last_grant;

  logic [NUM_SRC-1:0] grant_onehot;
  logic [63:0]        sel_data;
  logic [7:0]         sel_keep;
  logic               sel_last;
  logic               sel_valid;

  logic [NUM_SRC-1:0] arb_req;
  logic [NUM_SRC-1:0] rr_rot;
  logic [3:0]         rr_start;
  logic [3:0]         rr_off;
  logic [3:0]         rr_sum;
  logic [2:0]         rr_pick;
  logic               arb_any;

  logic               last_beat;
  logic               flush_end;

  // Source selected by the current grant.
  always_comb begin
    grant_onehot = '0;
    sel_data     = '0;
    sel_keep     = '0;
    sel_last     = 1'b0;
    sel_valid    = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_id == 3'(i)) begin
        grant_onehot[i] = 1'b1;
        sel_data        = s_tdata[i*64 +: 64];
        sel_keep        = s_tkeep[i*8 +: 8];
        sel_last        = s_tlast[i];
        sel_valid       = s_tvalid[i];
      end
    end
  end

  // Round-robin pick. The request vector is rotated so that last_grant+1
  // lands at bit 0; the lowest set bit of the rotated vector is the winner,
  // and adding the rotation back gives the source index.
  // While sending, the granted source's valid belongs to the beat being
  // consumed, so it is masked out of the back-to-back re-arbitration.
  always_comb begin
    arb_req = s_tvalid;
    if (state == ST_SEND) begin
      arb_req = s_tvalid & ~grant_onehot;
    end
    rr_start = (last_grant == LAST_IDX) ? 4'd0 : ({1'b0, last_grant} + 4'd1);
    rr_rot   = NUM_SRC'({arb_req, arb_req} >> rr_start);
    rr_off   = 4'd0;
    for (int j = NUM_SRC - 1; j >= 0; j--) begin
      if (rr_rot[j]) begin
        rr_off = 4'(j);
      end
    end
    rr_sum  = rr_start + rr_off;
    rr_pick = (rr_sum >= SRC_CNT) ? 3'(rr_sum - SRC_CNT) : rr_sum[2:0];
    arb_any = |arb_req;
  end

  // Datapath is purely combinational: zero added latency, and the granted
  // source sees Aurora's tready directly.
  always_comb begin
    m_tdata  = sel_data;
    m_tkeep  = sel_keep;
    m_tlast  = (state == ST_SEND) && sel_last;
    m_tvalid = (state == ST_SEND) && sel_valid;
    s_tready = '0;
    if (state == ST_SEND) begin
      s_tready = grant_onehot & {NUM_SRC{m_tready}};
    end else if (state == ST_FLUSH) begin
      // Drain the rest of the partial packet regardless of the link.
      s_tready = grant_onehot;
    end
  end

  assign busy      = (state != ST_IDLE);
  assign last_beat = (state == ST_SEND) && sel_valid && m_tready && sel_last;
  assign flush_end = (state == ST_FLUSH) && sel_valid && sel_last;

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state      <= ST_IDLE;
      grant_id   <= 3'd0;
      last_grant <= LAST_IDX;
      pkt_cnt    <= '0;
      drop_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (channel_up && arb_any) begin
            grant_id   <= rr_pick;
            last_grant <= rr_pick;
            state      <= ST_SEND;
          end
        end

        ST_SEND: begin
          // A completed last beat wins over a channel drop in the same
          // cycle: the packet has fully left, so it counts as forwarded.
          if (last_beat) begin
            if (pkt_cnt != CNT_MAX) begin
              pkt_cnt <= pkt_cnt + 1'b1;
            end
            if (channel_up && arb_any) begin
              grant_id   <= rr_pick;
              last_grant <= rr_pick;
            end else begin
              state <= ST_IDLE;
            end
          end else if (!channel_up) begin
            state <= ST_FLUSH;
          end
        end

        ST_FLUSH: begin
          // channel_up coming back is ignored; the packet is discarded whole.
          if (flush_end) begin
            if (drop_cnt != CNT_MAX) begin
              drop_cnt <= drop_cnt + 1'b1;
            end
            state <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/aurora_tx_arbiter.md
Name: aurora_tx_arbiter

Overview:
- Packet-level round-robin arbiter that shares one Aurora 64B/66B framing TX AXI-Stream port (s_axi_tx_*) between NUM_SRC requesters.
- Runs in the Aurora user_clk domain and sits between the application packet sources and the lane TX interface.
- A grant is held from first beat to tlast, so packets are never interleaved.
- New grants are gated by channel_up. A packet in flight when the channel drops is flushed (drained and discarded) and counted.

Parameters:
- NUM_SRC, 4, number of requesting sources (2..8).
- CNT_W, 16, width of the saturating packet and drop counters.

Ports:
- user_clk  in  1  Aurora user clock; every signal is synchronous to it.
- user_rst_n  in  1  asynchronous active-low reset.
- channel_up  in  1  Aurora channel_up, already in the user_clk domain.
- s_tdata  in  NUM_SRC*64  source data; source i occupies bits [i*64+63:i*64].
- s_tkeep  in  NUM_SRC*8  source byte enables, same packing.
- s_tlast  in  NUM_SRC  source end-of-packet.
- s_tvalid  in  NUM_SRC  source valid.
- s_tready  out  NUM_SRC  source ready.
- m_tdata  out  64  to Aurora s_axi_tx_tdata.
- m_tkeep  out  8  to Aurora s_axi_tx_tkeep.
- m_tlast  out  1  to Aurora s_axi_tx_tlast.
- m_tvalid  out  1  to Aurora s_axi_tx_tvalid.
- m_tready  in  1  from Aurora s_axi_tx_tready.
- grant_id  out  3  index of the current or last granted source.
- busy  out  1  high while in SEND or FLUSH.
- pkt_cnt  out  CNT_W  packets fully forwarded (saturating).
- drop_cnt  out  CNT_W  packets flushed on channel loss (saturating).

Behaviour:
- Reset: user_clk and user_rst_n are the only clock and reset. The reset is asynchronous and active-low.
- Reset values: state=IDLE, grant_id=0, last_grant=NUM_SRC-1 (source 0 wins first), busy=0, m_tvalid=0, s_tready=0, pkt_cnt=0, drop_cnt=0.
- Arbitration:
  - Round-robin starting at last_grant+1 and wrapping modulo NUM_SRC.
  - Evaluated combinationally on the current s_tvalid.
  - Result registered into grant_id and last_grant on the clock edge.
- State IDLE:
  - All s_tready=0, m_tvalid=0.
  - If channel_up=1 and any s_tvalid=1: register the grant and go to SEND. The first beat can transfer in the following cycle, so grant latency is 1 cycle.
- State SEND (g=grant_id):
  - m_tdata, m_tkeep, m_tlast and m_tvalid are combinationally muxed from source g.
  - s_tready[g]=m_tready; all other s_tready=0. No registering on the datapath, so data latency is 0.
  - Last beat (m_tvalid & m_tready & m_tlast): pkt_cnt+1, saturating at all-ones.
    - If channel_up=1 and any s_tvalid (excluding the beat just consumed) is set, re-arbitrate in the same edge and stay in SEND. Back-to-back packets have no bubble.
    - Otherwise go to IDLE.
  - channel_up=0 on a cycle with no completed last beat: go to FLUSH. That cycle's beat (if handshaken) is already delivered.
- State FLUSH:
  - m_tvalid=0 and s_tready[g]=1 (unconditional drain); other sources s_tready=0.
  - On s_tvalid[g] & s_tlast[g]: drop_cnt+1 (saturating), go to IDLE.
  - FLUSH ignores channel_up returning high; the partial packet is always discarded whole.
- Simultaneous events:
  - Last beat and channel_up falling in the same cycle: the packet counts as forwarded (pkt_cnt+1), and the block goes to IDLE rather than FLUSH.
- Stability rules:
  - grant_id changes only on arbitration edges.
  - busy = (state != IDLE).
  - A source deasserting s_tvalid mid-packet stalls the grant; the arbiter has no timeout.
- Reset asserted mid-packet: everything returns to reset values immediately. The Aurora side sees m_tvalid drop without tlast; upstream reset covers the link.
- Sources must obey AXI-Stream: tvalid is not withdrawn before its handshake. The arbiter does not check this.

Test Plan:
1. channel_up=1, source 2 sends a 3-beat packet, m_tready=1 -> grant_id=2 one cycle after tvalid; 3 beats appear unchanged on m_* with tlast on beat 3; pkt_cnt=1; busy returns to 0.
2. All 4 sources hold 2-beat packets continuously -> grant order 0,1,2,3,0, with no idle cycle between packets; pkt_cnt=5 after 10 beats.
3. Source 1 sends 4 beats while m_tready toggles 1,0,0,1,... -> s_tready[1] mirrors m_tready; no beat is lost or duplicated; data order is preserved.
4. Source 0 sends a 6-beat packet and channel_up falls after beat 2 -> m_tvalid=0 from the next cycle; beats 3–6 are drained with s_tready[0]=1; drop_cnt=1; pkt_cnt unchanged; with channel_up=0, IDLE issues no grant even while sources are valid.
5. channel_up falls on the same cycle as a handshaken tlast -> pkt_cnt+1, drop_cnt unchanged, state IDLE.
6. user_rst_n pulsed low mid-packet in SEND; separately, CNT_W=2 with 5 packets sent -> all outputs return to reset values asynchronously and the next grant goes to source 0; pkt_cnt saturates at 3.
